cdb_broadcaster: RTL and testbench

Transmitting end of the common data bus (CDB) in the out-of-order OTTER core. Collects completed results (reservation-station tag plus 32-bit value) from the functional units and buffers each unit's results in a small per-source FIFO. Grants one result per cycle round-robin and drives the registered `CDB_tag`/`CDB_val` broadcast. The map table, reservation stations and register file consume that broadcast.

---
 rtl/cpu_types.sv | 14 +
 rtl/cdb_fifo.sv | 56 +++++
 rtl/cdb_broadcaster.sv | 103 ++++++++++
 tb/tb_cdb_broadcaster.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types.sv
// Shared types for the out-of-order OTTER core: reservation-station tags and CDB payloads.
package cpu_types;

  localparam int NUM_FU = 4;

  typedef logic [4:0] RS_tag_type;
  localparam RS_tag_type INVALID = 5'h1F;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] val;
  } CDB_entry_type;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source CDB result FIFO; head is readable the cycle after the push that filled it.
// Push while full and pop while empty are ignored; flush and RST empty it.
module cdb_fifo
  import cpu_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          push_vld,
  input  CDB_entry_type push_dat,
  input  logic          pop_vld,
  output CDB_entry_type head_dat,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  CDB_entry_type mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push_vld && !full;
  assign pop_ok   = pop_vld && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmitter: per-source result FIFOs, round-robin grant, registered broadcast (>=1 cycle latency).
// Each source is backpressured via src_ready only while its own FIFO is full.
module cdb_broadcaster
  import cpu_types::*;
#(
  parameter int NUM_SRC = NUM_FU,
  parameter int DEPTH   = 2,
  localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  RS_tag_type [NUM_SRC-1:0] src_tag,
  input  logic [NUM_SRC-1:0][31:0] src_val,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic                     CDB_valid,
  output RS_tag_type               CDB_tag,
  output logic [31:0]              CDB_val,
  output logic [SW-1:0]            CDB_src
);

  localparam int          SW1  = SW + 1;
  localparam logic [SW:0] NSRC = SW1'(NUM_SRC);

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push_vld;
  logic [NUM_SRC-1:0] pop_vld;
  CDB_entry_type      head_dat [NUM_SRC];
  logic [SW-1:0]      rr;
  logic [SW-1:0]      rr_nxt;
  logic [SW-1:0]      grant_idx;
  logic               grant_vld;

  assign src_ready = RST ? '0 : ~full;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    CDB_entry_type push_dat;

    // INVALID-tagged results are handshaken but never stored.
    assign push_vld[i] = src_valid[i] && src_ready[i] && (src_tag[i] != INVALID);
    assign push_dat    = '{tag: src_tag[i], val: src_val[i]};

    cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK      (CLK),
      .RST      (RST),
      .flush    (flush),
      .push_vld (push_vld[i]),
      .push_dat (push_dat),
      .pop_vld  (pop_vld[i]),
      .head_dat (head_dat[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );
  end

  always_comb begin
    logic [SW:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    pop_vld   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr} + SW1'(k);
      if (cand >= NSRC) cand = cand - NSRC;
      if (!grant_vld && !empty[cand[SW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[SW-1:0];
      end
    end
    if (grant_vld) pop_vld[grant_idx] = 1'b1;
    rr_nxt = (grant_idx == SW'(NUM_SRC - 1)) ? '0 : grant_idx + SW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr        <= '0;
      CDB_valid <= 1'b0;
      CDB_tag   <= INVALID;
      CDB_val   <= '0;
      CDB_src   <= '0;
    end else if (flush) begin
      rr        <= '0;
      CDB_valid <= 1'b0;
      CDB_tag   <= INVALID;
      CDB_val   <= '0;
      CDB_src   <= '0;
    end else if (grant_vld) begin
      rr        <= rr_nxt;
      CDB_valid <= 1'b1;
      CDB_tag   <= head_dat[grant_idx].tag;
      CDB_val   <= head_dat[grant_idx].val;
      CDB_src   <= grant_idx;
    end else begin
      CDB_valid <= 1'b0;
      CDB_tag   <= INVALID;
      CDB_val   <= '0;
      CDB_src   <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: fixed vectors, directed corner sequences and random traffic
// checked every cycle against a queue-per-source reference model.
module tb_cdb_broadcaster;
  import cpu_types::*;

  localparam int N = 4;
  localparam int D = 2;

  logic               CLK;
  logic               RST;
  logic               flush;
  logic [N-1:0]       src_valid;
  RS_tag_type [N-1:0] src_tag;
  logic [N-1:0][31:0] src_val;
  logic [N-1:0]       src_ready;
  logic               CDB_valid;
  RS_tag_type         CDB_tag;
  logic [31:0]        CDB_val;
  logic [1:0]         CDB_src;

  cdb_broadcaster #(.NUM_SRC(N), .DEPTH(D)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_val   (src_val),
    .src_ready (src_ready),
    .CDB_valid (CDB_valid),
    .CDB_tag   (CDB_tag),
    .CDB_val   (CDB_val),
    .CDB_src   (CDB_src)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one queue per source, plus the registered broadcast.
  CDB_entry_type mq [N][$];
  int            m_rr;
  logic          m_vld;
  RS_tag_type    m_tag;
  logic [31:0]   m_val;
  int            m_src;

  task automatic m_idle();
    m_vld = 1'b0;
    m_tag = INVALID;
    m_val = '0;
    m_src = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr = 0;
    m_idle();
  endtask

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
    return r;
  endfunction

  task automatic model_edge(input logic [N-1:0] rdy);
    int g;
    CDB_entry_type e;
    if (flush) begin
      model_reset();
      return;
    end
    g = -1;
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_rr + k) % N;
      if (g < 0 && mq[s].size() != 0) g = s;
    end
    if (g >= 0) begin
      e     = mq[g].pop_front();
      m_vld = 1'b1;
      m_tag = e.tag;
      m_val = e.val;
      m_src = g;
      m_rr  = (g + 1) % N;
    end else begin
      m_idle();
    end
    for (int i = 0; i < N; i++)
      if (src_valid[i] && rdy[i] && src_tag[i] != INVALID)
        mq[i].push_back('{tag: src_tag[i], val: src_val[i]});
  endtask

  // One clock: check ready before the edge, advance model, check outputs after the edge.
  task automatic tick();
    logic [N-1:0] rdy;
    rdy = m_ready();
    chk("src_ready", 32'(src_ready), 32'(rdy));
    model_edge(rdy);
    @(posedge CLK);
    #1;
    chk("CDB_valid", 32'(CDB_valid), 32'(m_vld));
    chk("CDB_tag",   32'(CDB_tag),   32'(m_tag));
    chk("CDB_val",   CDB_val,        m_val);
    chk("CDB_src",   32'(CDB_src),   32'(m_src));
  endtask

  task automatic clear_inputs();
    flush     = 1'b0;
    src_valid = '0;
    src_tag   = '0;
    src_val   = '0;
  endtask

  typedef struct {
    logic               fl;
    logic [N-1:0]       vld;
    RS_tag_type [N-1:0] t;
    logic [N-1:0][31:0] v;
    logic [N-1:0]       e_rdy;
    logic               e_vld;
    RS_tag_type         e_tag;
    logic [31:0]        e_val;
    int                 e_src;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic [N-1:0] vld,
                              input RS_tag_type [N-1:0] t, input logic [N-1:0][31:0] v,
                              input logic ev, input RS_tag_type et, input logic [31:0] evl,
                              input int es);
    vec_t r;
    r.fl = fl; r.vld = vld; r.t = t; r.v = v; r.e_rdy = 4'hF;
    r.e_vld = ev; r.e_tag = et; r.e_val = evl; r.e_src = es;
    return r;
  endfunction

  localparam int NV = 16;
  vec_t vt [NV];

  RS_tag_type got0 [$];
  int   t0, t1, acc0;
  logic seen7, a0, a1;

  initial begin
    clear_inputs();
    RST = 1'b1;
    model_reset();

    // Reset state while RST is held.
    #7;
    chk("rst_valid", 32'(CDB_valid), 32'd0);
    chk("rst_tag",   32'(CDB_tag),   32'(INVALID));
    chk("rst_val",   CDB_val,        32'd0);
    chk("rst_src",   32'(CDB_src),   32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    #5;
    RST = 1'b0;
    #1;

    // Tags packed as {src3, src2, src1, src0}; expectations are outputs after the edge.
    vt[0]  = mk(0, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, {32'h0, 32'hAA, 32'h0, 32'h0}, 0, INVALID, 0, 0);
    vt[1]  = mk(0, 4'b0000, '0, '0, 1, 5'd5, 32'hAA, 2);
    vt[2]  = mk(0, 4'b0000, '0, '0, 0, INVALID, 0, 0);
    vt[3]  = mk(1, 4'b0000, '0, '0, 0, INVALID, 0, 0);
    vt[4]  = mk(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h44, 32'h33, 32'h22, 32'h11}, 0, INVALID, 0, 0);
    vt[5]  = mk(0, 4'b0000, '0, '0, 1, 5'd1, 32'h11, 0);
    vt[6]  = mk(0, 4'b0000, '0, '0, 1, 5'd2, 32'h22, 1);
    vt[7]  = mk(0, 4'b0000, '0, '0, 1, 5'd3, 32'h33, 2);
    vt[8]  = mk(0, 4'b0000, '0, '0, 1, 5'd4, 32'h44, 3);
    vt[9]  = mk(0, 4'b0000, '0, '0, 0, INVALID, 0, 0);
    vt[10] = mk(0, 4'b0010, {5'd0, 5'd0, INVALID, 5'd0}, {32'h0, 32'h0, 32'h1234, 32'h0}, 0, INVALID, 0, 0);
    vt[11] = mk(0, 4'b0000, '0, '0, 0, INVALID, 0, 0);
    vt[12] = mk(0, 4'b1001, {5'd9, 5'd0, 5'd0, 5'd8}, {32'h90, 32'h0, 32'h0, 32'h80}, 0, INVALID, 0, 0);
    vt[13] = mk(0, 4'b0000, '0, '0, 1, 5'd8, 32'h80, 0);
    vt[14] = mk(0, 4'b0000, '0, '0, 1, 5'd9, 32'h90, 3);
    vt[15] = mk(0, 4'b0000, '0, '0, 0, INVALID, 0, 0);

    for (int r = 0; r < NV; r++) begin
      flush = vt[r].fl; src_valid = vt[r].vld; src_tag = vt[r].t; src_val = vt[r].v;
      chk($sformatf("vec%0d_ready", r), 32'(src_ready), 32'(vt[r].e_rdy));
      tick();
      chk($sformatf("vec%0d_valid", r), 32'(CDB_valid), 32'(vt[r].e_vld));
      chk($sformatf("vec%0d_tag", r),   32'(CDB_tag),   32'(vt[r].e_tag));
      chk($sformatf("vec%0d_val", r),   CDB_val,        vt[r].e_val);
      chk($sformatf("vec%0d_src", r),   32'(CDB_src),   32'(vt[r].e_src));
    end
    clear_inputs();

    // Full FIFO on src 0 while src 1 streams and src 2 holds an early entry.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src_valid = 4'b0110;
    src_tag[1] = 5'd10; src_val[1] = 32'hA10;
    src_tag[2] = 5'd20; src_val[2] = 32'hA20;
    tick();
    src_valid = '0;
    t0 = 7; t1 = 11; acc0 = 0; seen7 = 1'b0;
    got0.delete();
    for (int c = 0; c < 16; c++) begin
      src_valid[0] = (t0 <= 9);  src_tag[0] = RS_tag_type'(t0); src_val[0] = 32'hB00 + 32'(t0);
      src_valid[1] = (t1 <= 14); src_tag[1] = RS_tag_type'(t1); src_val[1] = 32'hA00 + 32'(t1);
      a0 = src_valid[0] && src_ready[0];
      a1 = src_valid[1] && src_ready[1];
      if (a0 && t0 == 9) chk("tag9_after_tag7", 32'(seen7), 32'd1);
      tick();
      if (a0) begin
        acc0++;
        t0++;
        if (acc0 == 2) chk("src0_full_after_two", 32'(src_ready[0]), 32'd0);
      end
      if (a1) t1++;
      if (CDB_valid && CDB_src == 2'd0) begin
        got0.push_back(CDB_tag);
        if (CDB_tag == 5'd7) seen7 = 1'b1;
      end
    end
    clear_inputs();
    chk("src0_bcast_count", 32'(got0.size()), 32'd3);
    for (int k = 0; k < got0.size() && k < 3; k++)
      chk($sformatf("src0_order%0d", k), 32'(got0[k]), 32'(7 + k));

    // Flush with three entries buffered and a concurrent src 3 push of tag 6.
    src_valid = 4'b0111;
    src_tag = {5'd0, 5'd3, 5'd2, 5'd1};
    src_val = {32'h0, 32'hC3, 32'hC2, 32'hC1};
    tick();
    flush = 1'b1;
    src_valid = 4'b1000;
    src_tag[3] = 5'd6; src_val[3] = 32'hC6;
    tick();
    chk("flush_idle",  32'(CDB_valid), 32'd0);
    chk("flush_ready", 32'(src_ready), 32'hF);
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("flush_no_tag6", 32'(CDB_valid && CDB_tag == 5'd6), 32'd0);
    end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        src_valid[i] = ($urandom_range(0, 2) != 0);
        src_tag[i]   = RS_tag_type'($urandom_range(0, 31));
        src_val[i]   = $urandom;
      end
      tick();
    end
    clear_inputs();
    for (int c = 0; c < 8; c++) tick();

    // Asynchronous reset mid-cycle with entries buffered and a broadcast in flight.
    src_valid = 4'b0111;
    src_tag = {5'd0, 5'd3, 5'd2, 5'd1};
    src_val = {32'h0, 32'hD3, 32'hD2, 32'hD1};
    tick();
    src_tag = {5'd0, 5'd6, 5'd5, 5'd4};
    src_val = {32'h0, 32'hD6, 32'hD5, 32'hD4};
    tick();
    clear_inputs();
    #2;
    RST = 1'b1;
    #1;
    chk("arst_valid", 32'(CDB_valid), 32'd0);
    chk("arst_tag",   32'(CDB_tag),   32'(INVALID));
    chk("arst_val",   CDB_val,        32'd0);
    chk("arst_src",   32'(CDB_src),   32'd0);
    chk("arst_ready", 32'(src_ready), 32'd0);
    model_reset();
    #2;
    RST = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("arst_no_stale", 32'(CDB_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
